// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Bring-up reset sequencer for a bsg_link_sdr channel.
//
// After a start_i pulse the block walks the link resets through a fixed
// release order, holding each phase for hold_cycles_p cycles:
//   ASSERT -> TOKEN_HI -> TOKEN_LO -> UP_REL -> DOWN_REL -> DS_REL -> DONE
// A start_i in any state other than IDLE/DONE restarts the sequence.
//
// Parameters:
//   hold_cycles_p      cycles per phase (1..65535)
//   seq_count_width_p  width of the completed-sequence counter
//
// Ports:
//   clk_i               noc clock
//   reset_n_i           asynchronous active-low reset
//   start_i             single-cycle request to run / rerun the sequence
//   busy_o              sequence in progress
//   done_o              link fully out of reset
//   token_reset_o       to async_token_reset_i
//   uplink_reset_o      to core_uplink_reset_i
//   downlink_reset_o    to async_downlink_reset_i
//   downstream_reset_o  to core_downstream_reset_i
//   noc_reset_o         concentrator / arbiter reset on the noc side
//   seq_count_o         completed sequences, saturating
//
// Configuration macro:
//   BSG_LINK_SDR_RESET_SEQ_COUNT_EN  build the completed-sequence counter;
//                                    when undefined seq_count_o is tied to 0.

module bsg_link_sdr_reset_sequencer #(
   parameter int unsigned hold_cycles_p     = 16,
   parameter int unsigned seq_count_width_p = 8
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         start_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         token_reset_o,
   output logic                         uplink_reset_o,
   output logic                         downlink_reset_o,
   output logic                         downstream_reset_o,
   output logic                         noc_reset_o,
   output logic [seq_count_width_p-1:0] seq_count_o
);

   localparam int unsigned     CntW    = $clog2(hold_cycles_p + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(hold_cycles_p - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAssert,
      StTokenHi,
      StTokenLo,
      StUpRel,
      StDownRel,
      StDsRel,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic token_d, uplink_d, downlink_d, downstream_d, noc_d, busy_d, done_d;
   logic token_q, uplink_q, downlink_q, downstream_q, noc_q, busy_q, done_q;

   // Next-state and phase counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) state_d = StAssert;
         end
         default: begin
            // Restart wins over a phase advance in the same cycle.
            if (start_i) begin
               state_d = StAssert;
            end else if (cnt_q == LastCnt) begin
               unique case (state_q)
                  StAssert:  state_d = StTokenHi;
                  StTokenHi: state_d = StTokenLo;
                  StTokenLo: state_d = StUpRel;
                  StUpRel:   state_d = StDownRel;
                  StDownRel: state_d = StDsRel;
                  default:   state_d = StDone;
               endcase
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so every output
   // comes straight from a flop and tracks the current state.
   always_comb begin
      token_d      = 1'b0;
      uplink_d     = 1'b1;
      downlink_d   = 1'b1;
      downstream_d = 1'b1;
      noc_d        = 1'b1;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      unique case (state_d)
         StIdle: begin
         end
         StAssert: begin
            busy_d = 1'b1;
         end
         StTokenHi: begin
            token_d = 1'b1;
            busy_d  = 1'b1;
         end
         StTokenLo: begin
            busy_d = 1'b1;
         end
         StUpRel: begin
            uplink_d = 1'b0;
            busy_d   = 1'b1;
         end
         StDownRel: begin
            uplink_d   = 1'b0;
            downlink_d = 1'b0;
            busy_d     = 1'b1;
         end
         StDsRel: begin
            uplink_d     = 1'b0;
            downlink_d   = 1'b0;
            downstream_d = 1'b0;
            busy_d       = 1'b1;
         end
         StDone: begin
            uplink_d     = 1'b0;
            downlink_d   = 1'b0;
            downstream_d = 1'b0;
            noc_d        = 1'b0;
            done_d       = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         token_q      <= 1'b0;
         uplink_q     <= 1'b1;
         downlink_q   <= 1'b1;
         downstream_q <= 1'b1;
         noc_q        <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         token_q      <= token_d;
         uplink_q     <= uplink_d;
         downlink_q   <= downlink_d;
         downstream_q <= downstream_d;
         noc_q        <= noc_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign token_reset_o      = token_q;
   assign uplink_reset_o     = uplink_q;
   assign downlink_reset_o   = downlink_q;
   assign downstream_reset_o = downstream_q;
   assign noc_reset_o        = noc_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;

`ifdef BSG_LINK_SDR_RESET_SEQ_COUNT_EN
   logic [seq_count_width_p-1:0] seq_q, seq_d;

   // Count entries into DONE, saturating at all-ones.
   always_comb begin
      seq_d = seq_q;
      if (state_d == StDone && state_q != StDone && seq_q != '1) begin
         seq_d = seq_q + seq_count_width_p'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         seq_q <= '0;
      end else begin
         seq_q <= seq_d;
      end
   end

   assign seq_count_o = seq_q;
`else
   assign seq_count_o = '0;
`endif

endmodule
